// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit between the single-cycle core datapath and a
//   valid/ready data bus. It issues one bus transaction per load/store and
//   stalls the core until the access completes or times out. Load data is
//   lane-extracted and sign/zero-extended before it returns to the datapath.
//
// Parameters
//   TIMEOUT        cycles allowed in REQ+RESP before the access aborts (2..255)
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_mem_read/_write      load/store request for the current instruction
//   i_funct3               access size/sign (B, H, W, BU, HU)
//   i_data_addr            byte address from the ALU
//   i_write_data           store data (rs2)
//   o_read_data            extended load result, valid in DONE
//   o_stall                holds PC and register-file write while high
//   o_err                  one-cycle error pulse in DONE
//   o_bus_*, i_bus_*       valid/ready request channel plus rvalid response
//
// Build option
//   LSU_MISALIGN_TRAP_EN   when defined, misaligned H/W accesses skip the bus
//                          and finish with o_err; otherwise the low address
//                          bits below the access size are ignored.
//
// state | meaning
// IDLE  | waiting for a load/store request
// REQ   | o_bus_valid high, waiting for i_bus_ready
// RESP  | request accepted, waiting for i_bus_rvalid
// DONE  | core commits this cycle; always returns to IDLE

module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data,
   output logic        o_stall,
   output logic        o_err,
   output logic        o_bus_valid,
   input  logic        i_bus_ready,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   lsu_state_t  state, state_next;
   logic [7:0]  cnt, cnt_inc;
   logic [2:0]  f3_q;
   logic [1:0]  addr_lo_q;
   logic        req;
   logic        misalign;
   logic        timeout_hit;
   logic [31:0] store_wdata;
   logic [3:0]  store_be;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;

   assign req     = i_mem_read | i_mem_write;
   assign cnt_inc = cnt + 8'd1;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (i_funct3[1:0])
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = i_data_addr[0];
         default: misalign = (i_data_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // funct3[1:0] picks the size; 11 (and 110/111) fall through to word.
   always_comb begin
      store_wdata = i_write_data;
      store_be    = 4'b1111;
      case (i_funct3[1:0])
         2'b00: begin
            store_wdata = {4{i_write_data[7:0]}};
            store_be    = 4'b0001 << i_data_addr[1:0];
         end
         2'b01: begin
            store_wdata = {2{i_write_data[15:0]}};
            store_be    = i_data_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      load_byte = i_bus_rdata[7:0];
      case (addr_lo_q)
         2'b00: load_byte = i_bus_rdata[7:0];
         2'b01: load_byte = i_bus_rdata[15:8];
         2'b10: load_byte = i_bus_rdata[23:16];
         2'b11: load_byte = i_bus_rdata[31:24];
      endcase
      load_half = addr_lo_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_ext = {24'd0, load_byte};
         3'b001:  load_ext = {{16{load_half[15]}}, load_half};
         3'b101:  load_ext = {16'd0, load_half};
         default: load_ext = i_bus_rdata;
      endcase
   end

   always_comb begin
      state_next  = state;
      o_stall     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               o_stall    = 1'b1;
               state_next = misalign ? DONE : REQ;
            end
         end
         REQ: begin
            o_stall = 1'b1;
            if (cnt_inc == TIMEOUT_CNT) begin
               timeout_hit = 1'b1;
               state_next  = DONE;
            end else if (i_bus_ready) begin
               state_next = RESP;
            end
         end
         RESP: begin
            o_stall = 1'b1;
            // A response landing in the timeout cycle still completes cleanly.
            if (i_bus_rvalid) begin
               state_next = DONE;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               timeout_hit = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         f3_q        <= 3'd0;
         addr_lo_q   <= 2'd0;
         o_read_data <= 32'd0;
         o_err       <= 1'b0;
         o_bus_valid <= 1'b0;
         o_bus_we    <= 1'b0;
         o_bus_addr  <= 32'd0;
         o_bus_wdata <= 32'd0;
         o_bus_be    <= 4'd0;
      end else begin
         state <= state_next;
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (misalign) begin
                     o_err       <= 1'b1;
                     o_read_data <= 32'd0;
                  end else begin
                     cnt         <= 8'd0;
                     f3_q        <= i_funct3;
                     addr_lo_q   <= i_data_addr[1:0];
                     o_bus_valid <= 1'b1;
                     o_bus_we    <= i_mem_write;
                     o_bus_addr  <= {i_data_addr[31:2], 2'b00};
                     o_bus_wdata <= store_wdata;
                     o_bus_be    <= store_be;
                  end
               end
            end
            REQ: begin
               cnt <= cnt_inc;
               if (timeout_hit) begin
                  o_bus_valid <= 1'b0;
                  o_err       <= 1'b1;
                  o_read_data <= 32'd0;
               end else if (i_bus_ready) begin
                  o_bus_valid <= 1'b0;
               end
            end
            RESP: begin
               cnt <= cnt_inc;
               if (i_bus_rvalid) begin
                  o_read_data <= load_ext;
               end else if (timeout_hit) begin
                  o_err       <= 1'b1;
                  o_read_data <= 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] data_addr, write_data;
   logic [31:0] read_data;
   logic        stall, err;
   logic        bus_valid, bus_ready, bus_we, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checks   = 0;
   int failures = 0;

   int          r_stall, r_valid_cycles;
   logic        r_valid_seen, r_done, r_we, r_err;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0]  r_be;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_mem_read   (mem_read),
      .i_mem_write  (mem_write),
      .i_funct3     (funct3),
      .i_data_addr  (data_addr),
      .i_write_data (write_data),
      .o_read_data  (read_data),
      .o_stall      (stall),
      .o_err        (err),
      .o_bus_valid  (bus_valid),
      .i_bus_ready  (bus_ready),
      .o_bus_we     (bus_we),
      .o_bus_addr   (bus_addr),
      .o_bus_wdata  (bus_wdata),
      .o_bus_be     (bus_be),
      .i_bus_rvalid (bus_rvalid),
      .i_bus_rdata  (bus_rdata)
   );

   // Starts at posedge+1 in IDLE, returns at posedge+1 back in IDLE.
   // rdy_lat / rv_lat are the number of wait cycles before ready / rvalid.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] word, input int rdy_lat, input int rv_lat);
      int   req_n  = 0;
      int   resp_n = 0;
      logic in_resp = 1'b0;
      r_stall = 0; r_valid_cycles = 0; r_valid_seen = 1'b0; r_done = 1'b0;
      r_we = 1'b0; r_err = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_rdata = 32'd0; r_be = 4'd0;
      mem_read = rd; mem_write = wr; funct3 = f3; data_addr = addr; write_data = wd;
      bus_rdata = word;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (c > 0 && !stall) begin
            r_done  = 1'b1;
            r_rdata = read_data;
            r_err   = err;
            break;
         end
         if (stall) r_stall++;
         bus_ready  = 1'b0;
         bus_rvalid = 1'b0;
         if (bus_valid) begin
            r_valid_seen = 1'b1;
            r_valid_cycles++;
            r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be; r_we = bus_we;
            if (req_n >= rdy_lat) begin
               bus_ready = 1'b1;
               in_resp   = 1'b1;
            end
            req_n++;
         end else if (in_resp) begin
            if (resp_n >= rv_lat) bus_rvalid = 1'b1;
            resp_n++;
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; data_addr = 32'd0; write_data = 32'd0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus_valid, bus_we, err, stall} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got valid/we/err/stall=%b required 0000", {bus_valid, bus_we, err, stall});
      end
      checks++;
      if ({bus_addr, bus_wdata, bus_be, read_data} !== 100'd0) begin
         failures++;
         $display("FAIL reset_data: got addr=%h wdata=%h be=%b rdata=%h required all zero",
                  bus_addr, bus_wdata, bus_be, read_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL idle_comb_stall: got %b required 1", stall);
      end
      mem_read = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus_valid, stall} !== 2'b00) begin
         failures++;
         $display("FAIL idle_no_start: got valid/stall=%b required 00", {bus_valid, stall});
      end
   endtask

   task automatic test_store_word();
      run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
      checks++;
      if (r_done !== 1'b1 || r_stall != 3) begin
         failures++;
         $display("FAIL sw_stall: got done=%b stall_cycles=%0d required done=1 stall=3", r_done, r_stall);
      end
      checks++;
      if ({r_addr, r_be, r_we, r_wdata} !== {32'h100, 4'b1111, 1'b1, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL sw_bus: got addr=%h be=%b we=%b wdata=%h required 00000100 1111 1 deadbeef",
                  r_addr, r_be, r_we, r_wdata);
      end
      checks++;
      if (r_err !== 1'b0) begin
         failures++;
         $display("FAIL sw_err: got %b required 0", r_err);
      end
   endtask

   task automatic test_byte_loads();
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
      checks++;
      if (r_rdata !== 32'hFFFF_FF80 || r_addr !== 32'h100 || r_we !== 1'b0) begin
         failures++;
         $display("FAIL lb: got rdata=%h addr=%h we=%b required ffffff80 00000100 0", r_rdata, r_addr, r_we);
      end
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
      checks++;
      if (r_rdata !== 32'h0000_0080) begin
         failures++;
         $display("FAIL lbu: got %h required 00000080", r_rdata);
      end
      run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 0, 0);
      checks++;
      if (r_wdata !== 32'hA5A5_A5A5 || r_be !== 4'b0010) begin
         failures++;
         $display("FAIL sb: got wdata=%h be=%b required a5a5a5a5 0010", r_wdata, r_be);
      end
   endtask

   task automatic test_half();
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0, 0);
      checks++;
      if (r_wdata !== 32'hABCD_ABCD || r_be !== 4'b1100 || r_addr !== 32'h100) begin
         failures++;
         $display("FAIL sh: got wdata=%h be=%b addr=%h required abcdabcd 1100 00000100", r_wdata, r_be, r_addr);
      end
      run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hABCD_0000, 0, 0);
      checks++;
      if (r_rdata !== 32'h0000_ABCD) begin
         failures++;
         $display("FAIL lhu: got %h required 0000abcd", r_rdata);
      end
      run_access(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 32'h1234_8001, 0, 0);
      checks++;
      if (r_rdata !== 32'hFFFF_8001) begin
         failures++;
         $display("FAIL lh: got %h required ffff8001", r_rdata);
      end
   endtask

   task automatic test_misc_decode();
      run_access(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'h8000_0001, 0, 0);
      checks++;
      if (r_rdata !== 32'h8000_0001 || r_be !== 4'b1111) begin
         failures++;
         $display("FAIL f3_011_as_w: got rdata=%h be=%b required 80000001 1111", r_rdata, r_be);
      end
      run_access(1'b1, 1'b1, 3'b010, 32'h108, 32'h0102_0304, 32'h0, 0, 0);
      checks++;
      if (r_we !== 1'b1 || r_wdata !== 32'h0102_0304) begin
         failures++;
         $display("FAIL rd_wr_as_store: got we=%b wdata=%h required 1 01020304", r_we, r_wdata);
      end
   endtask

   task automatic test_latency();
      // 1 wait for ready, 1 wait for rvalid: rvalid lands in the timeout cycle and wins.
      run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1, 1);
      checks++;
      if (r_done !== 1'b1 || r_stall != 5 || r_err !== 1'b0 || r_rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL latency_edge: got done=%b stall=%0d err=%b rdata=%h required 1 5 0 12345678",
                  r_done, r_stall, r_err, r_rdata);
      end
      run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 0, 1000);
      checks++;
      if (r_done !== 1'b1 || r_stall != 5 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
         failures++;
         $display("FAIL resp_timeout: got done=%b stall=%0d err=%b rdata=%h required 1 5 1 00000000",
                  r_done, r_stall, r_err, r_rdata);
      end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hFFFF_FFFF, 1000, 0);
      checks++;
      if (r_done !== 1'b1 || r_valid_cycles != 4 || r_stall != 5) begin
         failures++;
         $display("FAIL req_timeout_len: got done=%b valid_cycles=%0d stall=%0d required 1 4 5",
                  r_done, r_valid_cycles, r_stall);
      end
      checks++;
      if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
         failures++;
         $display("FAIL req_timeout_err: got err=%b rdata=%h required 1 00000000", r_err, r_rdata);
      end
      checks++;
      if ({err, bus_valid} !== 2'b00) begin
         failures++;
         $display("FAIL err_pulse: got err/valid=%b required 00", {err, bus_valid});
      end
      bus_rdata = 32'h1357_9BDF; bus_rvalid = 1'b1;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      checks++;
      if (read_data !== 32'h0 || {err, stall} !== 2'b00) begin
         failures++;
         $display("FAIL late_rvalid: got rdata=%h err/stall=%b required 00000000 00", read_data, {err, stall});
      end
   endtask

   task automatic test_reset_in_resp();
      mem_read = 1'b1; funct3 = 3'b010; data_addr = 32'h300;
      @(posedge clk); #1;
      bus_ready = 1'b1;
      @(posedge clk); #1;
      bus_ready = 1'b0; mem_read = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({bus_valid, stall} !== 2'b00) begin
         failures++;
         $display("FAIL rst_resp_abort: got valid/stall=%b required 00", {bus_valid, stall});
      end
      bus_rdata = 32'h5555_AAAA; bus_rvalid = 1'b1;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      checks++;
      if (read_data !== 32'h0 || err !== 1'b0) begin
         failures++;
         $display("FAIL stale_rvalid: got rdata=%h err=%b required 00000000 0", read_data, err);
      end
      run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0102_0304, 0, 0);
      checks++;
      if (r_done !== 1'b1 || r_stall != 3 || r_rdata !== 32'h0102_0304) begin
         failures++;
         $display("FAIL lw_after_rst: got done=%b stall=%0d rdata=%h required 1 3 01020304",
                  r_done, r_stall, r_rdata);
      end
   endtask

   task automatic test_misaligned_word();
      run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++;
      if (r_valid_seen !== 1'b0 || r_err !== 1'b1 || r_stall != 1 || r_rdata !== 32'h0) begin
         failures++;
         $display("FAIL lw_misalign_trap: got valid_seen=%b err=%b stall=%0d rdata=%h required 0 1 1 00000000",
                  r_valid_seen, r_err, r_stall, r_rdata);
      end
`else
      checks++;
      if (r_addr !== 32'h100 || r_rdata !== 32'hCAFE_F00D || r_err !== 1'b0 || r_stall != 3) begin
         failures++;
         $display("FAIL lw_misalign_pass: got addr=%h rdata=%h err=%b stall=%0d required 00000100 cafef00d 0 3",
                  r_addr, r_rdata, r_err, r_stall);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_byte_loads();
      test_half();
      test_misc_decode();
      test_latency();
      test_timeout();
      test_reset_in_resp();
      test_misaligned_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the single-cycle core datapath. It takes the datapath's data address and store data, plus the load/store control and `funct3`. It runs one transaction on a valid/ready data bus and stalls the core until the access completes. It also returns byte/halfword/word-extracted, sign- or zero-extended load data to the datapath's read-data input.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles spent in REQ+RESP before the access is aborted with an error (range 2..255).

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_mem_read`, in, 1: load request for the current instruction.
- `i_mem_write`, in, 1: store request for the current instruction.
- `i_funct3`, in, 3: access size/sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `i_data_addr`, in, 32: byte address (the datapath ALU result).
- `i_write_data`, in, 32: store data (the datapath rs2 value).
- `o_read_data`, out, 32: extended load result, valid in DONE.
- `o_stall`, out, 1: holds PC and register-file write while high.
- `o_err`, out, 1: one-cycle error pulse in DONE.
- `o_bus_valid`, out, 1: request valid.
- `i_bus_ready`, in, 1: request accepted.
- `o_bus_we`, out, 1: 1 = write.
- `o_bus_addr`, out, 32: word-aligned address (`[1:0]` = 00).
- `o_bus_wdata`, out, 32: lane-replicated store data.
- `o_bus_be`, out, 4: byte enables.
- `i_bus_rvalid`, in, 1: response valid; completes both loads and stores.
- `i_bus_rdata`, in, 32: response word.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, request present (`i_mem_read | i_mem_write`):
  - Latch the word address, be, wdata, we, funct3 and `addr[1:0]`.
  - Go to REQ.
  - `o_stall` = 1 combinationally in this cycle.
- REQ:
  - `o_bus_valid` = 1, all bus outputs stable.
  - `i_bus_ready` → RESP.
- RESP: `i_bus_rvalid` → capture and extend the read data, then go to DONE. Any `rvalid` seen while not in RESP is ignored.
- DONE:
  - `o_stall` = 0, so the core commits.
  - Next state is always IDLE. The held request is not re-issued.
- Both `i_mem_read` and `i_mem_write` high: treated as a store.
- Store formatting:
  - SB: byte replicated to all four lanes; be = `0001 << addr[1:0]`.
  - SH: halfword replicated; be = `0011 << (2*addr[1])`.
  - SW: be = 1111.
- Load extraction: lane selected by `addr[1:0]` (B/BU) or `addr[1]` (H/HU). B/H sign-extend; BU/HU zero-extend; W passes through.
- `funct3` 011, 110 or 111: treated as W.
- Timeout:
  - An 8-bit counter clears on IDLE→REQ and increments each cycle in REQ or RESP.
  - When it reaches `TIMEOUT` without completion, go to DONE with `o_err` = 1 and `o_read_data` = 0.
  - `o_bus_valid` drops on the next edge.
  - If `rvalid` arrives in the timeout cycle, `rvalid` wins and there is no error.

## Timing
- Reset values (from the clock edge with `i_rst` high): state IDLE; `o_bus_valid`, `o_bus_we`, `o_err` = 0; `o_bus_addr`, `o_bus_wdata`, `o_bus_be`, `o_read_data` = 0; counter 0; `o_stall` = 0 unless a request is present.
- Best-case access takes 4 cycles: IDLE, REQ (ready same cycle), RESP (rvalid same cycle), DONE. `o_stall` is high for the first 3.
- Each extra cycle of `ready` or `rvalid` latency adds one stall cycle.
- All bus outputs and `o_read_data` are registered. `o_stall` is combinational from state and the request inputs.
- Reset in REQ or RESP: abort, go to IDLE, `o_bus_valid` low after the edge, and any pending response is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0.
  - A misaligned access goes IDLE→DONE with no bus activity: `o_stall` is high for 1 cycle, then `o_err` = 1 in DONE.
  - Load data is 0 and nothing is written.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalignment check.
  - Address bits below the access size are ignored (H uses `addr[1]`, W uses 00) and the access proceeds normally.

## Test plan
- Reset, then SW to addr 0x100 with data 0xDEADBEEF, ready and rvalid immediate → `o_bus_addr` = 0x100, be = 1111, `o_stall` high 3 cycles, `o_err` = 0.
- LB from 0x103 with bus word 0x80FF_1234 → `o_read_data` = 0xFFFF_FF80. LBU from the same address → 0x0000_0080.
- SH to 0x102 with data 0x0000_ABCD → wdata = 0xABCD_ABCD, be = 1100. LHU from 0x102 with word 0xABCD_0000 → 0x0000_ABCD.
- `TIMEOUT` = 4, ready never asserted → DONE after 4 REQ cycles, `o_err` pulse, `o_read_data` = 0. A later `rvalid` is ignored.
- `i_rst` asserted in RESP → IDLE next edge, `o_bus_valid` = 0. A stale `rvalid` then has no effect, and a new LW completes normally.
- LW from 0x101:
  - With the macro: no `o_bus_valid`, `o_err` = 1, 1 stall cycle.
  - Without the macro: bus addr = 0x100, data returned unmodified.
